// File: rtl/mld_7_4_sequencer.sv
// Load/decode sequencer for the (7,4) majority-logic decoder shift register.
// Loads N bits serially, then drains N corrected bits that also recirculate into the register head.
module mld_7_4_sequencer #(
   parameter int N  = 7,
   parameter int K  = 4,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          abort,
   input  logic          rx_valid,
   input  logic          rx_bit,
   output logic          rx_ready,
   input  logic          sr_out,
   input  logic          maj_in,
   output logic          sr_shift,
   output logic          sr_din,
   output logic          dec_valid,
   output logic          dec_bit,
   output logic          dec_msg,
   output logic          dec_last,
   input  logic          dec_ready,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] err_count
);

   typedef enum logic {LOAD, DECODE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] err_acc;
   logic          last_cnt;
   logic          rx_acc;
   logic          dec_acc;

   assign last_cnt = (cnt == CW'(N - 1));

   always_comb begin
      rx_ready  = (state == LOAD);
      dec_valid = (state == DECODE);
      busy      = (state == DECODE);
      dec_bit   = sr_out ^ maj_in;
      dec_msg   = dec_valid && (cnt < CW'(K));
      dec_last  = dec_valid && last_cnt;
      // The corrected bit is written back so the register ends up holding the decoded word.
      sr_din    = (state == LOAD) ? rx_bit : dec_bit;
      sr_shift  = !abort && ((state == LOAD) ? rx_valid : dec_ready);
      rx_acc    = rx_ready && rx_valid && !abort;
      dec_acc   = dec_valid && dec_ready && !abort;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= LOAD;
         cnt       <= '0;
         err_acc   <= '0;
         err_count <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state   <= LOAD;
            cnt     <= '0;
            err_acc <= '0;
         end else if (rx_acc) begin
            if (last_cnt) begin
               cnt     <= '0;
               err_acc <= '0;
               state   <= DECODE;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else if (dec_acc) begin
            if (last_cnt) begin
               // Count includes the correction applied to the final bit itself.
               err_count <= err_acc + CW'(maj_in);
               done      <= 1'b1;
               cnt       <= '0;
               state     <= LOAD;
            end else begin
               cnt     <= cnt + CW'(1);
               err_acc <= err_acc + CW'(maj_in);
            end
         end
      end
   end

endmodule

// File: tb/tb_mld_7_4_sequencer.sv
// Randomized self-checking bench for mld_7_4_sequencer with a behavioural shift-register model
// and a per-frame reference (decoded bit i = received bit i xor majority flag i).
module tb_mld_7_4_sequencer;
   localparam int N  = 7;
   localparam int K  = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset, abort, rx_valid, rx_bit, sr_out, maj_in, dec_ready;
   logic          rx_ready, sr_shift, sr_din, dec_valid, dec_bit, dec_msg, dec_last, busy, done;
   logic [CW-1:0] err_count;

   logic [N-1:0]  sr_q;
   logic [CW-1:0] last_err;
   int            vec_count  = 0;
   int            miscompares = 0;

   mld_7_4_sequencer #(.N(N), .K(K), .CW(CW)) dut (
      .clk(clk), .reset(reset), .abort(abort), .rx_valid(rx_valid), .rx_bit(rx_bit),
      .rx_ready(rx_ready), .sr_out(sr_out), .maj_in(maj_in), .sr_shift(sr_shift),
      .sr_din(sr_din), .dec_valid(dec_valid), .dec_bit(dec_bit), .dec_msg(dec_msg),
      .dec_last(dec_last), .dec_ready(dec_ready), .busy(busy), .done(done),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   // External 7-stage shift register: head gets sr_din, tail drives sr_out.
   assign sr_out = sr_q[N-1];
   always @(posedge clk) if (sr_shift === 1'b1) sr_q <= {sr_q[N-2:0], sr_din};

   // mode >= 0: percent probability; -1: every other cycle; -2: pattern 1,0,0 repeating
   function automatic logic pick(input int mode, input int cyc);
      if (mode == -1) return (cyc % 2) == 0;
      if (mode == -2) return (cyc % 3) == 0;
      return $urandom_range(99, 0) < mode;
   endfunction

   function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
      int s = 0;
      for (int i = 0; i < N; i++) s += v[i];
      return CW'(s);
   endfunction

   // Full frame; bits[N-1] is the first bit sent; maj[N-1] is the flag for decoded index 0.
   task automatic do_frame(input logic [N-1:0] bits, input logic [N-1:0] maj,
                           input int vmode, input int rmode, input string tag);
      int idx = 0;
      int cyc = 0;
      logic exp_bit;
      logic [CW-1:0] exp_err = popcnt(maj);
      while (idx < N && cyc < 300) begin
         @(negedge clk);
         abort = 1'b0; rx_valid = pick(vmode, cyc); dec_ready = 1'($urandom); maj_in = 1'($urandom);
         rx_bit = rx_valid ? bits[N-1-idx] : 1'($urandom);
         #1;
         vec_count++; if (rx_ready !== 1'b1 || dec_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL %s load_flags: rx_ready=%b dec_valid=%b busy=%b want 1,0,0 (bit %0d)", tag, rx_ready, dec_valid, busy, idx); end
         vec_count++; if (sr_shift !== rx_valid || (rx_valid && sr_din !== rx_bit)) begin
            miscompares++; $display("FAIL %s load_shift: sr_shift=%b sr_din=%b want %b,%b", tag, sr_shift, sr_din, rx_valid, rx_bit); end
         @(posedge clk);
         if (rx_valid) idx++;
         cyc++;
      end
      vec_count++; if (idx < N) begin miscompares++; $display("FAIL %s load_timeout: accepted %0d want %0d", tag, idx, N); end
      idx = 0; cyc = 0;
      while (idx < N && cyc < 300) begin
         @(negedge clk);
         abort = 1'b0; dec_ready = pick(rmode, cyc); maj_in = maj[N-1-idx];
         rx_valid = 1'($urandom); rx_bit = 1'($urandom);
         exp_bit = bits[N-1-idx] ^ maj[N-1-idx];
         #1;
         vec_count++; if (dec_valid !== 1'b1 || busy !== 1'b1 || rx_ready !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL %s dec_flags: dec_valid=%b busy=%b rx_ready=%b done=%b want 1,1,0,0 (idx %0d)", tag, dec_valid, busy, rx_ready, done, idx); end
         vec_count++; if (dec_bit !== exp_bit || sr_din !== exp_bit) begin
            miscompares++; $display("FAIL %s dec_bit: dec_bit=%b sr_din=%b want %b (idx %0d)", tag, dec_bit, sr_din, exp_bit, idx); end
         vec_count++; if (dec_msg !== (idx < K) || dec_last !== (idx == N-1)) begin
            miscompares++; $display("FAIL %s dec_tags: msg=%b last=%b want %b,%b (idx %0d)", tag, dec_msg, dec_last, idx < K, idx == N-1, idx); end
         vec_count++; if (sr_shift !== dec_ready) begin
            miscompares++; $display("FAIL %s dec_shift: sr_shift=%b want %b", tag, sr_shift, dec_ready); end
         @(posedge clk);
         if (dec_ready) idx++;
         cyc++;
      end
      vec_count++; if (idx < N) begin miscompares++; $display("FAIL %s dec_timeout: transfers %0d want %0d", tag, idx, N); end
      @(negedge clk);
      rx_valid = 1'b0; dec_ready = 1'b0; maj_in = 1'b0;
      #1;
      vec_count++; if (done !== 1'b1 || err_count !== exp_err || rx_ready !== 1'b1 || dec_valid !== 1'b0) begin
         miscompares++; $display("FAIL %s frame_end: done=%b err_count=%0d rx_ready=%b dec_valid=%b want 1,%0d,1,0", tag, done, err_count, rx_ready, dec_valid, exp_err); end
      last_err = exp_err;
      @(negedge clk); #1;
      vec_count++; if (done !== 1'b0) begin miscompares++; $display("FAIL %s done_width: done=%b want 0", tag, done); end
      $display("frame %s: bits=%b maj=%b err_count=%0d", tag, bits, maj, err_count);
   endtask

   task automatic test_reset();
      #3;
      vec_count++; if (rx_ready !== 1'b1 || dec_valid !== 1'b0 || busy !== 1'b0 || sr_shift !== 1'b0) begin
         miscompares++; $display("FAIL reset_comb: rx_ready=%b dec_valid=%b busy=%b sr_shift=%b want 1,0,0,0", rx_ready, dec_valid, busy, sr_shift); end
      vec_count++; if (done !== 1'b0 || err_count !== '0) begin
         miscompares++; $display("FAIL reset_regs: done=%b err_count=%0d want 0,0", done, err_count); end
      @(negedge clk); reset = 1'b0;
      $display("reset: rx_ready=%b err_count=%0d", rx_ready, err_count);
   endtask

   task automatic test_clean_frame();
      do_frame(7'b1101000, 7'b0000000, 100, 100, "clean");
   endtask

   task automatic test_single_error();
      do_frame(7'b1100000, 7'b0001000, 100, 100, "single_err");
   endtask

   task automatic test_backpressure();
      do_frame(7'b0110100, 7'b0000010, 100, -2, "backpressure");
   endtask

   task automatic test_rx_gaps();
      do_frame(7'b1011001, 7'b1000000, -1, 100, "rx_gaps");
   endtask

   task automatic test_abort();
      do_frame(7'b0011010, 7'b0100100, 100, 100, "pre_abort");
      for (int i = 0; i < N; i++) begin
         @(negedge clk); rx_valid = 1'b1; rx_bit = 1'($urandom); dec_ready = 1'b0;
         @(posedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); rx_valid = 1'b0; dec_ready = 1'b1; maj_in = 1'b1;
         @(posedge clk);
      end
      @(negedge clk); abort = 1'b1; dec_ready = 1'b1; maj_in = 1'b1; #1;
      vec_count++; if (sr_shift !== 1'b0) begin miscompares++; $display("FAIL abort_shift: sr_shift=%b want 0", sr_shift); end
      @(negedge clk); abort = 1'b0; dec_ready = 1'b0; maj_in = 1'b0; #1;
      vec_count++; if (rx_ready !== 1'b1 || dec_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("FAIL abort_state: rx_ready=%b dec_valid=%b busy=%b done=%b want 1,0,0,0", rx_ready, dec_valid, busy, done); end
      vec_count++; if (err_count !== last_err) begin
         miscompares++; $display("FAIL abort_err_count: err_count=%0d want %0d", err_count, last_err); end
      @(negedge clk); #1;
      vec_count++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: done=%b want 0", done); end
      $display("abort: err_count=%0d kept", err_count);
      do_frame(7'b1110001, 7'b0000000, 100, 100, "post_abort");
   endtask

   task automatic test_async_reset();
      do_frame(7'b0101010, 7'b0010001, 100, 100, "pre_reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); rx_valid = 1'b1; rx_bit = 1'($urandom);
         @(posedge clk);
      end
      @(negedge clk); rx_valid = 1'b0; #2; reset = 1'b1; #1;
      vec_count++; if (err_count !== '0 || done !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0 || dec_valid !== 1'b0) begin
         miscompares++; $display("FAIL async_reset: err_count=%0d done=%b rx_ready=%b busy=%b dec_valid=%b want 0,0,1,0,0", err_count, done, rx_ready, busy, dec_valid); end
      last_err = '0;
      @(negedge clk); reset = 1'b0;
      $display("async reset: err_count=%0d", err_count);
      do_frame(7'b1001110, 7'b0000100, 100, 100, "post_reset");
   endtask

   task automatic test_random();
      for (int f = 0; f < 10; f++) begin
         do_frame(N'($urandom), N'($urandom), int'($urandom_range(100, 30)),
                  int'($urandom_range(100, 30)), $sformatf("rand%0d", f));
      end
   endtask

   initial begin
      sr_q = '0; last_err = '0;
      reset = 1'b1; abort = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0; maj_in = 1'b0; dec_ready = 1'b0;
      test_reset();
      test_clean_frame();
      test_single_error();
      test_backpressure();
      test_rx_gaps();
      test_abort();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end
endmodule
